// File: rtl/fc3_classifier_if.sv
// Memory-side bus of the fc3 classifier: activation/weight/bias reads, logit writes and result.
// The classifier core uses the master modport; the memories and the consumer use slave.
interface fc3_classifier_if #(
  parameter int DATA_WIDTH = 16,
  parameter int IN_AW      = 7,
  parameter int W_AW       = 10,
  parameter int OUT_AW     = 4
);
  logic                         en;
  logic        [IN_AW-1:0]      in_read_addr;
  logic signed [DATA_WIDTH-1:0] in_read_data;
  logic        [W_AW-1:0]       weight_addr;
  logic signed [DATA_WIDTH-1:0] weight_data;
  logic        [OUT_AW-1:0]     bias_read_addr;
  logic signed [DATA_WIDTH-1:0] bias_read_data;
  logic                         logit_write_ena;
  logic        [OUT_AW-1:0]     logit_write_addr;
  logic signed [DATA_WIDTH-1:0] logit_write_data;
  logic        [OUT_AW-1:0]     class_out;
  logic                         FC_done;

  modport master (
    input  en, in_read_data, weight_data, bias_read_data,
    output in_read_addr, weight_addr, bias_read_addr,
           logit_write_ena, logit_write_addr, logit_write_data,
           class_out, FC_done
  );

  modport slave (
    output en, in_read_data, weight_data, bias_read_data,
    input  in_read_addr, weight_addr, bias_read_addr,
           logit_write_ena, logit_write_addr, logit_write_data,
           class_out, FC_done
  );
endinterface

// File: rtl/fc3_classifier.sv
// Final LeNet-5 stage: ten 84-input dot products plus bias, saturated to Q7.8 logits,
// with a running argmax whose index is presented alongside a level done flag.
module fc3_classifier #(
  parameter int DATA_WIDTH = 16,
  parameter int INPUT_MAP  = 84,
  parameter int OUTPUT_MAP = 10,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_WIDTH  = 32
) (
  input  logic             clk,
  input  logic             rst,
  fc3_classifier_if.master bus
);

  localparam int IN_AW  = $clog2(INPUT_MAP);
  localparam int OUT_AW = $clog2(OUTPUT_MAP);
  localparam int PROD_W = 2 * DATA_WIDTH;

  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH + 1)'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH + 1)'(-(2 ** (DATA_WIDTH - 1)));

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC,
    S_DRAIN,
    S_BIAS,
    S_DONE
  } state_t;

  state_t                       state;
  logic        [IN_AW-1:0]      i_cnt;       // next activation index to issue
  logic        [OUT_AW-1:0]     j;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [DATA_WIDTH-1:0] max_val;
  logic                         prod_valid;  // read data on the bus belongs to this neuron

  logic signed [PROD_W-1:0]     prod;
  logic signed [ACC_WIDTH-1:0]  acc_shifted;
  logic signed [ACC_WIDTH:0]    logit_sum;
  logic signed [DATA_WIDTH-1:0] logit_sat;

  assign prod = PROD_W'(bus.in_read_data) * PROD_W'(bus.weight_data);

  // NOTE: every variable gets a value before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    acc_shifted = acc >>> FRAC_BITS;
    logit_sum   = {acc_shifted[ACC_WIDTH-1], acc_shifted} + (ACC_WIDTH + 1)'(bus.bias_read_data);
    logit_sat   = logit_sum[DATA_WIDTH-1:0];
    if (logit_sum > SAT_MAX) begin
      logit_sat = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
    end else if (logit_sum < SAT_MIN) begin
      logit_sat = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= S_IDLE;
      i_cnt                <= '0;
      j                    <= '0;
      acc                  <= '0;
      max_val              <= '0;
      prod_valid           <= 1'b0;
      bus.in_read_addr     <= '0;
      bus.weight_addr      <= '0;
      bus.bias_read_addr   <= '0;
      bus.logit_write_ena  <= 1'b0;
      bus.logit_write_addr <= '0;
      bus.logit_write_data <= '0;
      bus.class_out        <= '0;
      bus.FC_done          <= 1'b0;
    end else begin
      bus.logit_write_ena <= 1'b0;
      bus.FC_done         <= 1'b0;

      if (!bus.en) begin
        state      <= S_IDLE;
        prod_valid <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: begin
            state              <= S_MAC;
            j                  <= '0;
            acc                <= '0;
            prod_valid         <= 1'b0;
            bus.in_read_addr   <= '0;
            bus.weight_addr    <= '0;
            bus.bias_read_addr <= '0;
            i_cnt              <= IN_AW'(1);
          end

          S_MAC: begin
            if (prod_valid) begin
              acc <= acc + ACC_WIDTH'(prod);
            end
            prod_valid <= 1'b1;
            if (i_cnt == IN_AW'(INPUT_MAP)) begin
              state <= S_DRAIN;
            end else begin
              // Weights are row-major, so the weight address simply walks forward across neurons.
              bus.in_read_addr <= i_cnt;
              bus.weight_addr  <= bus.weight_addr + 1'b1;
              i_cnt            <= i_cnt + 1'b1;
            end
          end

          S_DRAIN: begin
            acc        <= acc + ACC_WIDTH'(prod);
            prod_valid <= 1'b0;
            state      <= S_BIAS;
          end

          S_BIAS: begin
            bus.logit_write_ena  <= 1'b1;
            bus.logit_write_addr <= j;
            bus.logit_write_data <= logit_sat;
            // Strict compare keeps the lowest index on ties.
            if (j == '0 || logit_sat > max_val) begin
              max_val       <= logit_sat;
              bus.class_out <= j;
            end
            if (j == OUT_AW'(OUTPUT_MAP - 1)) begin
              state <= S_DONE;
            end else begin
              state              <= S_MAC;
              j                  <= j + 1'b1;
              acc                <= '0;
              bus.in_read_addr   <= '0;
              bus.weight_addr    <= bus.weight_addr + 1'b1;
              bus.bias_read_addr <= j + 1'b1;
              i_cnt              <= IN_AW'(1);
            end
          end

          S_DONE: begin
            // Rises the cycle after the last logit write, once class_out has settled.
            bus.FC_done <= 1'b1;
          end

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fc3_classifier.sv
// Directed bench for fc3_classifier: behavioural memories, per-write timing/value checks,
// argmax, saturation, abort/rerun and asynchronous reset mid-run.
module tb_fc3_classifier;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fc3_classifier_if bus ();

  fc3_classifier dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] act_mem [84];
  logic [15:0] w_mem   [840];
  logic [15:0] b_mem   [10];
  logic [15:0] exp_logit [10];

  // Synchronous-read memories with one cycle of latency.
  always @(posedge clk) begin
    bus.in_read_data   <= act_mem[bus.in_read_addr];
    bus.weight_data    <= w_mem[bus.weight_addr];
    bus.bias_read_data <= b_mem[bus.bias_read_addr];
  end

  int checks = 0;
  int errors = 0;

  int          wr_n;
  logic [3:0]  wr_addr [16];
  logic [15:0] wr_data [16];
  int          wr_cyc  [16];
  int          done_cyc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic fill(input logic [15:0] a, input logic [15:0] w, input logic [15:0] b);
    foreach (act_mem[i]) act_mem[i] = a;
    foreach (w_mem[i])   w_mem[i]   = w;
    foreach (b_mem[i])   b_mem[i]   = b;
  endtask

  task automatic set_exp(input logic [15:0] v);
    foreach (exp_logit[i]) exp_logit[i] = v;
  endtask

  task automatic load_dot();
    fill(16'h0100, 16'h0000, 16'h0000);
    for (int jj = 0; jj < 10; jj++) begin
      for (int ii = 0; ii <= jj; ii++) w_mem[jj * 84 + ii] = 16'h0100;
      exp_logit[jj] = 16'((jj + 1) * 256);
    end
  endtask

  // Raises en; the next rising edge is edge 0. stop_at >= 0 either drops en or pulses rst there.
  task automatic run(input int stop_at, input bit do_reset);
    wr_n     = 0;
    done_cyc = -1;
    bus.en   = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(posedge clk);
      #1;
      if (bus.logit_write_ena) begin
        if (wr_n < 16) begin
          wr_addr[wr_n] = bus.logit_write_addr;
          wr_data[wr_n] = bus.logit_write_data;
          wr_cyc[wr_n]  = k;
        end
        wr_n++;
      end
      if (bus.FC_done) begin
        done_cyc = k;
        break;
      end
      if (k == stop_at && do_reset) begin
        #2 rst = 1'b0;
        #1;
        check("rst addrs", {11'd0, bus.in_read_addr, bus.weight_addr, bus.bias_read_addr}, 32'd0);
        check("rst write", {11'd0, bus.logit_write_ena, bus.logit_write_addr, bus.logit_write_data}, 32'd0);
        check("rst result", {27'd0, bus.class_out, bus.FC_done}, 32'd0);
        break;
      end
      if (k == stop_at) bus.en = 1'b0;
      if (stop_at >= 0 && k == stop_at + 20) break;
    end
  endtask

  task automatic check_frame(input string name, input logic [3:0] exp_class);
    check($sformatf("%s writes", name), wr_n, 10);
    for (int jj = 0; jj < 10 && jj < wr_n; jj++) begin
      check($sformatf("%s addr%0d", name, jj), {28'd0, wr_addr[jj]}, jj);
      check($sformatf("%s logit%0d", name, jj), {16'd0, wr_data[jj]}, {16'd0, exp_logit[jj]});
      check($sformatf("%s cycle%0d", name, jj), wr_cyc[jj], 86 + 86 * jj);
    end
    check($sformatf("%s done_cycle", name), done_cyc, 861);
    check($sformatf("%s class", name), {28'd0, bus.class_out}, {28'd0, exp_class});
    repeat (4) @(posedge clk);
    #1;
    check($sformatf("%s done_hold", name), {31'd0, bus.FC_done}, 32'd1);
    bus.en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check($sformatf("%s done_clear", name), {31'd0, bus.FC_done}, 32'd0);
    check($sformatf("%s class_kept", name), {28'd0, bus.class_out}, {28'd0, exp_class});
  endtask

  initial begin
    bus.en = 1'b0;
    fill(16'h0000, 16'h0000, 16'h0000);
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    check("reset addrs", {11'd0, bus.in_read_addr, bus.weight_addr, bus.bias_read_addr}, 32'd0);
    check("reset write", {11'd0, bus.logit_write_ena, bus.logit_write_addr, bus.logit_write_data}, 32'd0);
    check("reset result", {27'd0, bus.class_out, bus.FC_done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Bias-only: only neuron 7 is non-zero.
    fill(16'h0000, 16'h0000, 16'h0000);
    b_mem[7] = 16'h0500;
    set_exp(16'h0000);
    exp_logit[7] = 16'h0500;
    run(-1, 1'b0);
    check_frame("bias", 4'd7);

    // All-zero logits: ties resolve to class 0.
    fill(16'h0000, 16'h0000, 16'h0000);
    set_exp(16'h0000);
    run(-1, 1'b0);
    check_frame("tie", 4'd0);

    // Row j has j+1 weights of 1.0 against inputs of 1.0.
    load_dot();
    run(-1, 1'b0);
    check_frame("dot", 4'd9);

    // Abort mid neuron 4: neurons 0..3 written, no done, then a clean rerun.
    run(400, 1'b0);
    check("abort writes", wr_n, 4);
    for (int jj = 0; jj < 4 && jj < wr_n; jj++) begin
      check($sformatf("abort logit%0d", jj), {16'd0, wr_data[jj]}, {16'd0, exp_logit[jj]});
    end
    check("abort no_done", {31'd0, done_cyc < 0}, 32'd1);
    check("abort quiet", {31'd0, bus.logit_write_ena}, 32'd0);
    run(-1, 1'b0);
    check_frame("rerun", 4'd9);

    // Asynchronous reset during neuron 3, released with en still high.
    run(300, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    run(-1, 1'b0);
    check_frame("post_reset", 4'd9);

    // Full-scale inputs: 84 * 0x3FFF0001 wraps to -5504940; >>>8 = -21504; +32767 = 0x2BFF.
    fill(16'h7FFF, 16'h7FFF, 16'h7FFF);
    set_exp(16'h2BFF);
    run(-1, 1'b0);
    check_frame("sat_pos_wrap", 4'd0);

    // 84 * -0x3FFF8000 wraps to 2752512; >>>8 = 10752; -32768 = -22016 = 0xAA00.
    fill(16'h7FFF, 16'h8000, 16'h8000);
    set_exp(16'hAA00);
    run(-1, 1'b0);
    check_frame("sat_neg_wrap", 4'd0);

    // One full-scale product: 0x3FFF0001 >>> 8 = 0x3FFF00, +0x7FFF clamps to 0x7FFF.
    fill(16'h0000, 16'h7FFF, 16'h7FFF);
    act_mem[0] = 16'h7FFF;
    set_exp(16'h7FFF);
    run(-1, 1'b0);
    check_frame("sat_hi", 4'd0);

    // -1073709056 >>> 8 = -4194176, -32768 clamps to 0x8000.
    fill(16'h0000, 16'h8000, 16'h8000);
    act_mem[0] = 16'h7FFF;
    set_exp(16'h8000);
    run(-1, 1'b0);
    check_frame("sat_lo", 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
